uart_cmd_parser: RTL and testbench
==================================

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 500000: maximum clk cycles between frame bytes (10 ms at 50 MHz).
REQ-002 SHALL have parameter LED_W, default 6: width of the LED register.
REQ-003 SHALL have port clk_50m  input  1  system clock, 50 MHz.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rx_data  input  8  received byte from the UART receiver.
REQ-006 SHALL have port rx_done  input  1  byte-ready strobe/level from the receiver; the rising edge marks a new byte.
REQ-007 SHALL have port tx_data  output  8  reply byte to the UART transmitter.
REQ-008 SHALL have port tx_valid  output  1  one-cycle request to transmit tx_data.
REQ-009 SHALL have port tx_busy  input  1  transmitter busy; rises the cycle after tx_valid and falls when the stop bit ends.
REQ-010 SHALL have port led  output  LED_W  LED control register.

Function
REQ-011 SHALL register rx_done and detect its 0->1 edge; each edge samples rx_data as exactly one byte.
REQ-012 SHALL parse frames {0xA5, CMD, DATA, CSUM}, where CSUM = CMD XOR DATA.
REQ-013 SHALL use states IDLE, GET_CMD, GET_DATA, GET_CSUM, EXEC, TX_B0, TX_B1, TX_B2, TX_WAIT.
REQ-014 IDLE: byte 0xA5 -> GET_CMD; any other byte is ignored.
REQ-015 GET_CMD -> GET_DATA -> GET_CSUM: each transition occurs on a byte; GET_CSUM -> EXEC on the checksum byte.
REQ-016 In GET_CMD, GET_DATA and GET_CSUM, a free-running counter SHALL reset on every byte.
REQ-017 When the counter reaches TIMEOUT_CYCLES-1, the parser SHALL return to IDLE silently: no reply and no LED change.
REQ-018 EXEC, one cycle: on checksum mismatch, status=0xE1 and led is unchanged.
REQ-019 CMD 0x01, toggle: when DATA < LED_W, led[DATA] is inverted and status=0x00; otherwise status=0xE2.
REQ-020 CMD 0x02, write: led = DATA[LED_W-1:0] and status=0x00; the upper DATA bits are ignored.
REQ-021 CMD 0x03, read: led is unchanged and status=0x00.
REQ-022 Any other CMD: status=0xE3 and led is unchanged.
REQ-023 A led update SHALL be visible the cycle after EXEC.
REQ-024 The reply SHALL be 3 bytes: 0x5A, status, {0, led} zero-extended to 8 bits; led is sampled after the EXEC update.
REQ-025 Each TX_Bn state SHALL wait for tx_busy=0, then drive tx_data and pulse tx_valid for exactly 1 cycle, then enter TX_WAIT.
REQ-026 TX_WAIT SHALL wait for tx_busy 1->0 and then advance to the next byte; after byte 2 it goes to IDLE.
REQ-027 Bytes arriving during EXEC or any TX state SHALL be discarded, not buffered.
REQ-028 If a 0xA5 appears as a CMD/DATA/CSUM byte, it SHALL be treated as data, not as a resync.
REQ-029 If an rx edge and a timeout occur in the same cycle, the byte SHALL win: the counter clears and the state advances.
REQ-030 tx_valid SHALL never be asserted while tx_busy=1.
REQ-031 Latency: the first tx_valid SHALL occur 2 cycles after the CSUM rx edge when tx_busy=0.

Reset
REQ-032 While reset_n=0: state=IDLE, led=0, tx_valid=0, tx_data=0x00, timeout counter=0, rx edge register=0.
REQ-033 Reset asserted mid-frame or mid-reply SHALL abort immediately; the partial reply is not resumed after release.
REQ-034 After release, the first rx_done edge SHALL be detected only on a genuine 0->1 transition; a level already high is not counted.

Structure
REQ-035 A shared package uart_cmd_pkg SHALL hold the header constants 0xA5 and 0x5A, the CMD codes 0x01/0x02/0x03, the status codes 0x00/0xE1/0xE2/0xE3, and the state encoding.
REQ-036 The timeout counter SHALL be a sub-module, byte_timeout, with inputs clear, enable and expired; its width SHALL be $clog2(TIMEOUT_CYCLES).
REQ-037 The parser FSM and the led register SHALL reside in uart_cmd_parser.

Verification
REQ-038 Frame A5 01 03 02 with led=0 -> led=0x08; reply 5A 00 08.
REQ-039 Frame A5 02 3F 3D -> led=0x3F; then A5 03 00 03 -> reply 5A 00 3F.
REQ-040 Frame A5 01 00 00, a bad checksum -> led unchanged; reply 5A E1 xx, where xx is the current led.
REQ-041 Frame A5 01 07 06 -> reply 5A E2 and led unchanged; frame A5 09 00 09 -> reply 5A E3.
REQ-042 Send A5 01, wait TIMEOUT_CYCLES, then send 03 02 -> no reply and led unchanged; a subsequent full frame is accepted normally.
REQ-043 Hold tx_busy=1 for 1000 cycles after the first reply byte -> no tx_valid during that time; assert reset_n=0 mid-reply -> led=0 and tx_valid=0, and no further reply bytes after release.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared constants for the UART command parser: frame headers, command
// codes, reply status codes and the parser state encoding.
package uart_cmd_pkg;

    localparam logic [7:0] HDR_RX = 8'hA5;  // first byte of every command frame
    localparam logic [7:0] HDR_TX = 8'h5A;  // first byte of every reply

    localparam logic [7:0] CMD_TOGGLE = 8'h01;
    localparam logic [7:0] CMD_WRITE  = 8'h02;
    localparam logic [7:0] CMD_READ   = 8'h03;

    localparam logic [7:0] ST_OK       = 8'h00;
    localparam logic [7:0] ST_BAD_CSUM = 8'hE1;
    localparam logic [7:0] ST_BAD_IDX  = 8'hE2;
    localparam logic [7:0] ST_BAD_CMD  = 8'hE3;

    typedef enum logic [3:0] {
        IDLE,
        GET_CMD,
        GET_DATA,
        GET_CSUM,
        EXEC,
        TX_B0,
        TX_B1,
        TX_B2,
        TX_WAIT
    } state_e;

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Byte-level link between a UART PHY (receiver + transmitter) and the
// command parser. master = PHY side, slave = parser side.
interface uart_cmd_parser_if;

    logic [7:0] rx_data;
    logic       rx_done;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_busy;

    modport master (
        output rx_data,
        output rx_done,
        output tx_busy,
        input  tx_data,
        input  tx_valid
    );

    modport slave (
        input  rx_data,
        input  rx_done,
        input  tx_busy,
        output tx_data,
        output tx_valid
    );

endinterface

// File: rtl/byte_timeout.sv
// Inter-byte timeout counter. Counts while enabled, restarts on clear, and
// flags expired for one cycle when TIMEOUT_CYCLES-1 is reached.
module byte_timeout #(
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // Guard keeps the counter at least one bit wide for tiny timeouts.
    localparam int              CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expired = enable && (cnt_q == LAST);

    // Next count: idle or a fresh byte parks the counter at zero.
    always_comb begin
        // NOTE: assign a default first so every path drives cnt_d (no latch).
        cnt_d = cnt_q + 1'b1;
        if (clear || !enable || expired) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// Command parser: receives {A5, CMD, DATA, CSUM} frames byte by byte,
// executes toggle/write/read on the LED register and sends a 3-byte reply
// {5A, status, led}. LED_W must be between 1 and 8.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 500000,
    parameter int LED_W          = 6
) (
    input  logic             clk_50m,
    input  logic             reset_n,
    input  logic [7:0]       rx_data,
    input  logic             rx_done,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_busy,
    output logic [LED_W-1:0] led
);

    state_e           state_q, state_d;
    logic             rx_done_q;
    logic             rx_armed_q;  // blocks a level that was already high at reset release
    logic             tx_busy_q;
    logic [7:0]       cmd_q, cmd_d;
    logic [7:0]       data_q, data_d;
    logic [7:0]       status_q, status_d;
    logic             csum_ok_q, csum_ok_d;
    logic [1:0]       tx_idx_q, tx_idx_d;
    logic [LED_W-1:0] led_q, led_d;

    logic rx_edge;
    logic tx_fall;
    logic in_frame;
    logic expired;

    assign rx_edge  = rx_armed_q && rx_done && !rx_done_q;
    assign tx_fall  = tx_busy_q && !tx_busy;
    assign in_frame = state_q inside {GET_CMD, GET_DATA, GET_CSUM};
    assign led      = led_q;

    byte_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk_50m),
        .reset_n (reset_n),
        .clear   (rx_edge),
        .enable  (in_frame),
        .expired (expired)
    );

    // State register.
    always_ff @(posedge clk_50m or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a byte always beats a simultaneous timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (rx_edge && rx_data == HDR_RX) state_d = GET_CMD;
            GET_CMD:  if (rx_edge) state_d = GET_DATA; else if (expired) state_d = IDLE;
            GET_DATA: if (rx_edge) state_d = GET_CSUM; else if (expired) state_d = IDLE;
            GET_CSUM: if (rx_edge) state_d = EXEC;     else if (expired) state_d = IDLE;
            EXEC:     state_d = TX_B0;
            TX_B0, TX_B1, TX_B2: if (!tx_busy) state_d = TX_WAIT;
            TX_WAIT: begin
                if (tx_fall) begin
                    case (tx_idx_q)
                        2'd0:    state_d = TX_B1;
                        2'd1:    state_d = TX_B2;
                        default: state_d = IDLE;
                    endcase
                end
            end
            default:  state_d = IDLE;
        endcase
    end

    // Datapath next values: capture frame fields, execute, count reply bytes.
    always_comb begin
        cmd_d     = cmd_q;
        data_d    = data_q;
        csum_ok_d = csum_ok_q;
        status_d  = status_q;
        led_d     = led_q;
        tx_idx_d  = tx_idx_q;
        case (state_q)
            GET_CMD:  if (rx_edge) cmd_d = rx_data;
            GET_DATA: if (rx_edge) data_d = rx_data;
            GET_CSUM: if (rx_edge) csum_ok_d = (rx_data == (cmd_q ^ data_q));
            EXEC: begin
                tx_idx_d = 2'd0;
                if (!csum_ok_q) begin
                    status_d = ST_BAD_CSUM;
                end else begin
                    case (cmd_q)
                        CMD_TOGGLE: begin
                            if ({24'd0, data_q} < LED_W) begin
                                led_d    = led_q ^ (LED_W'(1) << data_q);
                                status_d = ST_OK;
                            end else begin
                                status_d = ST_BAD_IDX;
                            end
                        end
                        CMD_WRITE: begin
                            led_d    = data_q[LED_W-1:0];
                            status_d = ST_OK;
                        end
                        CMD_READ: status_d = ST_OK;
                        default:  status_d = ST_BAD_CMD;
                    endcase
                end
            end
            TX_WAIT:  if (tx_fall) tx_idx_d = tx_idx_q + 2'd1;
            default:  ;
        endcase
    end

    // Datapath and input-sampling registers.
    always_ff @(posedge clk_50m or negedge reset_n) begin
        if (!reset_n) begin
            rx_done_q  <= 1'b0;
            rx_armed_q <= 1'b0;
            tx_busy_q  <= 1'b0;
            cmd_q      <= 8'h00;
            data_q     <= 8'h00;
            csum_ok_q  <= 1'b0;
            status_q   <= 8'h00;
            tx_idx_q   <= 2'd0;
            led_q      <= '0;
        end else begin
            rx_done_q  <= rx_done;
            rx_armed_q <= 1'b1;
            tx_busy_q  <= tx_busy;
            cmd_q      <= cmd_d;
            data_q     <= data_d;
            csum_ok_q  <= csum_ok_d;
            status_q   <= status_d;
            tx_idx_q   <= tx_idx_d;
            led_q      <= led_d;
        end
    end

    // Outputs: a reply byte is offered only while the transmitter is free.
    always_comb begin
        tx_data = 8'h00;
        case (state_q)
            TX_B0:   tx_data = HDR_TX;
            TX_B1:   tx_data = status_q;
            TX_B2:   tx_data = 8'(led_q);
            default: tx_data = 8'h00;
        endcase
        tx_valid = (state_q inside {TX_B0, TX_B1, TX_B2}) && !tx_busy;
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: directed frame table, hand-written timing
// sequences (timeout boundary, discard, busy hold, reset) and random frames
// checked against a behavioural model of the command rules.
module tb_uart_cmd_parser;
    import uart_cmd_pkg::*;

    localparam int TO     = 40;
    localparam int LED_W  = 6;
    localparam int TX_LEN = 8;

    logic             clk_50m = 1'b0;
    logic             reset_n = 1'b0;
    logic [LED_W-1:0] led;

    uart_cmd_parser_if bus ();

    uart_cmd_parser #(
        .TIMEOUT_CYCLES(TO),
        .LED_W         (LED_W)
    ) dut (
        .clk_50m  (clk_50m),
        .reset_n  (reset_n),
        .rx_data  (bus.rx_data),
        .rx_done  (bus.rx_done),
        .tx_data  (bus.tx_data),
        .tx_valid (bus.tx_valid),
        .tx_busy  (bus.tx_busy),
        .led      (led)
    );

    always #10 clk_50m = ~clk_50m;

    int cyc = 0;
    always @(posedge clk_50m) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input logic [31:0] act, input logic [31:0] exp, input string name);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    // ---------------- transmitter model ----------------
    logic [7:0] txq[$];
    int         txcyc[$];
    logic       saw_valid = 1'b0;
    logic       hold_busy = 1'b0;
    int         busy_cnt  = 0;

    always @(negedge clk_50m) begin
        saw_valid = bus.tx_valid;
        if (bus.tx_valid) begin
            check(32'(bus.tx_busy), 32'd0, "valid_while_busy");
            txq.push_back(bus.tx_data);
            txcyc.push_back(cyc);
        end
    end

    always @(posedge clk_50m) begin
        #1;
        if (!reset_n) busy_cnt = 0;
        else if (saw_valid) busy_cnt = TX_LEN;
        else if (busy_cnt > 0) busy_cnt--;
        bus.tx_busy = hold_busy || (busy_cnt > 0);
    end

    // ---------------- reference model ----------------
    task automatic model_exec(input logic [7:0] cmd, input logic [7:0] data, input logic [7:0] csum,
                              input logic [LED_W-1:0] led_in,
                              output logic [7:0] status, output logic [LED_W-1:0] led_out);
        int idx;
        led_out = led_in;
        idx     = int'(data);
        if ((cmd ^ data) != csum)  status = 8'hE1;
        else if (cmd == 8'h01) begin
            if (idx < LED_W) begin
                led_out = led_in ^ LED_W'(2 ** idx);
                status  = 8'h00;
            end else status = 8'hE2;
        end
        else if (cmd == 8'h02) begin
            led_out = LED_W'(int'(data) % (2 ** LED_W));
            status  = 8'h00;
        end
        else if (cmd == 8'h03) status = 8'h00;
        else status = 8'hE3;
    endtask

    // ---------------- stimulus helpers (stay in posedge+1 phase) ----------------
    int last_edge_cyc = 0;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_50m);
            #1;
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) tick(1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data   = b;
        bus.rx_done   = 1'b1;
        last_edge_cyc = cyc;
        tick(2);
        bus.rx_done = 1'b0;
        tick(2);
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] data, input logic [7:0] csum);
        send_byte(8'hA5);
        send_byte(cmd);
        send_byte(data);
        send_byte(csum);
    endtask

    task automatic wait_reply(input int n);
        int t = 0;
        while (txq.size() < n && t < 400) begin
            tick(1);
            t++;
        end
        tick(15);
    endtask

    task automatic check_reply(input logic [7:0] status, input logic [LED_W-1:0] exp_led, input string name);
        logic [23:0] got = '0;
        for (int i = 0; i < 3; i++) if (i < txq.size()) got[23-8*i -: 8] = txq[i];
        check(32'(txq.size()), 32'd3, {name, "_nbytes"});
        check(32'(got), {8'd0, 8'h5A, status, 8'(exp_led)}, {name, "_reply"});
        check(32'(led), 32'(exp_led), {name, "_led"});
    endtask

    task automatic run_frame(input logic [7:0] cmd, input logic [7:0] data, input logic [7:0] csum,
                             input logic [7:0] status, input logic [LED_W-1:0] exp_led, input string name);
        int csum_cyc;
        txq.delete();
        txcyc.delete();
        send_frame(cmd, data, csum);
        csum_cyc = last_edge_cyc;
        wait_reply(3);
        check_reply(status, exp_led, name);
        check(32'((txcyc.size() > 0) ? txcyc[0] - csum_cyc : -1), 32'd2, {name, "_latency"});
    endtask

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic [7:0]       cmd;
        logic [7:0]       data;
        logic [7:0]       csum;
        logic [7:0]       status;
        logic [LED_W-1:0] led;
    } vec_t;

    vec_t vecs[9];
    logic [LED_W-1:0] m_led;

    initial begin
        logic [7:0]       st;
        logic [7:0]       cmd, data, csum, noise;
        logic [LED_W-1:0] nl;
        int               e0, kind;

        vecs[0] = '{8'h01, 8'h03, 8'h02, 8'h00, 6'h08};
        vecs[1] = '{8'h02, 8'h3F, 8'h3D, 8'h00, 6'h3F};
        vecs[2] = '{8'h03, 8'h00, 8'h03, 8'h00, 6'h3F};
        vecs[3] = '{8'h01, 8'h00, 8'h00, 8'hE1, 6'h3F};
        vecs[4] = '{8'h01, 8'h07, 8'h06, 8'hE2, 6'h3F};
        vecs[5] = '{8'h09, 8'h00, 8'h09, 8'hE3, 6'h3F};
        vecs[6] = '{8'h02, 8'hC5, 8'hC7, 8'h00, 6'h05};
        vecs[7] = '{8'h01, 8'h05, 8'h04, 8'h00, 6'h25};
        vecs[8] = '{8'h01, 8'hA5, 8'hA4, 8'hE2, 6'h25};

        // Reset state, with rx_done already high when reset is released.
        bus.tx_busy = 1'b0;
        bus.rx_data = 8'hA5;
        bus.rx_done = 1'b1;
        tick(5);
        @(negedge clk_50m);
        check(32'(led), 32'd0, "reset_led");
        check(32'(bus.tx_valid), 32'd0, "reset_tx_valid");
        check(32'(bus.tx_data), 32'd0, "reset_tx_data");
        @(posedge clk_50m);
        #1;
        reset_n = 1'b1;
        tick(3);
        bus.rx_done = 1'b0;
        tick(2);
        send_byte(8'h01);
        send_byte(8'h03);
        send_byte(8'h02);
        tick(100);
        check(32'(txq.size()), 32'd0, "held_level_no_reply");
        check(32'(led), 32'd0, "held_level_led");

        // Directed frames.
        for (int i = 0; i < 9; i++)
            run_frame(vecs[i].cmd, vecs[i].data, vecs[i].csum, vecs[i].status, vecs[i].led,
                      $sformatf("vec%0d", i));
        m_led = 6'h25;

        // Timeout mid-frame: the tail of the frame must be ignored.
        txq.delete();
        send_byte(8'hA5);
        send_byte(8'h01);
        tick(TO + 5);
        send_byte(8'h03);
        send_byte(8'h02);
        tick(60);
        check(32'(txq.size()), 32'd0, "timeout_no_reply");
        check(32'(led), 32'(m_led), "timeout_led");
        run_frame(8'h01, 8'h00, 8'h01, 8'h00, 6'h24, "after_timeout");

        // Byte on the exact expiry cycle is accepted.
        e0 = cyc;
        send_byte(8'hA5);
        wait_until(e0 + TO);
        run_frame_tail: begin
            txq.delete();
            txcyc.delete();
            send_byte(8'h02);
            send_byte(8'h2A);
            send_byte(8'h28);
            wait_reply(3);
            check_reply(8'h00, 6'h2A, "edge_on_expiry");
        end

        // One cycle later the frame is already dropped.
        txq.delete();
        e0 = cyc;
        send_byte(8'hA5);
        wait_until(e0 + TO + 1);
        send_byte(8'h01);
        send_byte(8'h03);
        send_byte(8'h02);
        tick(60);
        check(32'(txq.size()), 32'd0, "edge_after_expiry_no_reply");
        check(32'(led), 32'h2A, "edge_after_expiry_led");

        // Bytes arriving during the reply are discarded.
        txq.delete();
        send_frame(8'h01, 8'h01, 8'h00);
        send_frame(8'h02, 8'h3F, 8'h3D);
        wait_reply(3);
        tick(100);
        check_reply(8'h00, 6'h28, "discard_during_tx");

        // Transmitter held busy, then reset in the middle of the reply.
        txq.delete();
        send_frame(8'h03, 8'h00, 8'h03);
        for (int t = 0; t < 200 && txq.size() < 1; t++) tick(1);
        hold_busy = 1'b1;
        tick(1000);
        check(32'(txq.size()), 32'd1, "busy_hold_one_byte");
        reset_n = 1'b0;
        @(negedge clk_50m);
        check(32'(led), 32'd0, "midreply_reset_led");
        check(32'(bus.tx_valid), 32'd0, "midreply_reset_tx_valid");
        @(posedge clk_50m);
        #1;
        tick(2);
        reset_n   = 1'b1;
        hold_busy = 1'b0;
        tick(200);
        check(32'(txq.size()), 32'd1, "no_resume_after_reset");
        run_frame(8'h02, 8'h15, 8'h17, 8'h00, 6'h15, "after_reset");
        m_led = 6'h15;

        // Random frames against the model, with non-header noise in IDLE.
        for (int n = 0; n < 30; n++) begin
            kind = $urandom_range(0, 9);
            data = 8'($urandom_range(0, 255));
            if (kind <= 3) begin
                cmd  = 8'h01;
                data = 8'($urandom_range(0, 7));
            end
            else if (kind <= 6) cmd = 8'h02;
            else if (kind == 7) cmd = 8'h03;
            else cmd = 8'($urandom_range(0, 255));
            csum = cmd ^ data;
            if ($urandom_range(0, 4) == 0) csum = csum ^ 8'($urandom_range(1, 255));
            for (int k = $urandom_range(0, 2); k > 0; k--) begin
                noise = 8'($urandom_range(0, 255));
                if (noise == 8'hA5) noise = 8'h00;
                send_byte(noise);
            end
            model_exec(cmd, data, csum, m_led, st, nl);
            run_frame(cmd, data, csum, st, nl, $sformatf("rand%0d", n));
            m_led = nl;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
